bit_serial_adder: RTL and testbench
===================================

# bit_serial_adder

Bit-serial adder controller that consumes the team's single-bit full-adder cell. It accepts two WIDTH-bit operands and a carry-in on a start pulse, then feeds them LSB-first through one full-adder cell, one bit per clock, with a registered carry. It returns the WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between the board-level operand registers (switch/UART capture) and the result display logic on the Mimas V2 board.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while in SHIFT.
- done  output  1  single-cycle pulse; high only in DONE.
- sum  output  WIDTH  registered result; holds until the next DONE.
- cout  output  1  registered carry-out; holds until the next DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on start=1. On that edge:
  - a_sr<=a, b_sr<=b, carry_q<=cin, bit_cnt<=0, sum_sr<=0.
- In SHIFT, every edge:
  - The full-adder cell computes s and c from a_sr[0], b_sr[0] and carry_q.
  - a_sr and b_sr shift right by one.
  - sum_sr shifts right by one, with s inserted at bit WIDTH-1.
  - carry_q<=c, and bit_cnt increments.
- SHIFT -> DONE on the edge that processes bit WIDTH-1 (bit_cnt==WIDTH-1). On that same edge:
  - sum is loaded with the final shifted sum_sr value, including that edge's s.
  - cout is loaded with that edge's c.
- DONE -> IDLE unconditionally on the next edge.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1). There is no overflow flag.
- start is ignored in SHIFT and DONE. Operands are not re-sampled and no request is queued.
- a, b and cin may change freely after the start edge without affecting the result.
- WIDTH=1: SHIFT lasts exactly one edge.
- Reset, at any time including mid-SHIFT, asynchronously forces:
  - state=IDLE, busy=0, done=0, sum=0, cout=0, all shift registers=0, carry_q=0, bit_cnt=0.
  - A partial result is discarded.
  - After reset is released, the next start is treated as a fresh request.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0.
- Edge numbering: the start edge is E0.
- busy is high after E0 through E(WIDTH-1), i.e. for WIDTH cycles.
- done is high for exactly the one cycle between EWIDTH and E(WIDTH+1).
- sum and cout update at EWIDTH. They are valid in the same cycle done is high.
- Earliest next accepted start: the edge E(WIDTH+1) is the DONE->IDLE edge, so start is not sampled there. The earliest accepted next start is E(WIDTH+2).
- Throughput: one addition per WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package/include (adder_defs):
  - state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - default WIDTH constant.
- Counter width: $clog2(WIDTH) with a floor of 1 bit.
- One sub-module, full_adder_cell: purely combinational, s = a^b^c, cout = ab|bc|ac. It is instantiated once.
- FSM, shift registers, counter and output registers live in bit_serial_adder.

## Test plan
- WIDTH=8:
  - Reset, then a=0x5A, b=0x3C, cin=0, start for 1 cycle -> busy high 8 cycles, done single pulse 8 edges after start, sum=0x96, cout=0.
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (full carry ripple).
  - a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1. Then a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0.
  - Start a=0x12, b=0x34. Pulse start again at E3 with a=0xFF, b=0xFF, and change a/b every cycle -> result 0x46/0 unaffected, only one done pulse.
  - Start a=0x80, b=0x80. Assert rst_n=0 at E4 -> busy, done, sum, cout drop to 0 immediately. No done pulse appears. A new start after release with a=0x01, b=0x02 yields sum=0x03.
- WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1, done one edge after the single SHIFT edge.
- Holding start high continuously is accepted every WIDTH+2 cycles. Check three consecutive results against a reference model.

Source files
------------

// File: rtl/adder_defs_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package adder_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; purely combinational.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: streams operands LSB-first through one full-adder cell,
// one bit per clock, and returns {cout,sum} with a one-cycle done pulse.
module bit_serial_adder
  import adder_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nx;
  logic             carry_q;
  logic [CW-1:0]    bit_cnt;
  logic             fa_s, fa_c;
  logic             last_bit;

  full_adder_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .c    (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // New sum bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  always_comb begin
    sum_nx            = sum_sr >> 1;
    sum_nx[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      bit_cnt <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            bit_cnt <= '0;
            sum_sr  <= '0;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          sum_sr  <= sum_nx;
          carry_q <= fa_c;
          bit_cnt <= bit_cnt + 1'b1;
          if (last_bit) begin
            sum  <= sum_nx;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=1 instances)
// against an arithmetic reference model.
module tb_bit_serial_adder;

  localparam int W = 8;
  localparam int P = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic         start1 = 1'b0;
  logic [0:0]   a1 = '0, b1 = '0;
  logic         cin1 = 1'b0;
  logic         busy1, done1, cout1;
  logic [0:0]   sum1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  bit_serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // Drives one request and observes a fixed window of W+3 samples after the start edge.
  task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         output int lat, output int busy_cnt, output int done_cnt,
                         output logic [W-1:0] rs, output logic rc);
    lat = -1; busy_cnt = 0; done_cnt = 0; rs = '0; rc = 1'b0;
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int k = 1; k <= W + 3; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) begin lat = k; rs = sum; rc = cout; end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_w8 got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
    end
    checks++;
    if ({busy1, done1, sum1, cout1} !== 4'b0) begin
      failures++;
      $display("[TB] FAIL reset_w1 got busy=%b done=%b sum=%h cout=%b want all 0", busy1, done1, sum1, cout1);
    end
    rst_n = 1'b1;
  endtask

  task automatic check_add(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    int lat, bc, dc, total;
    logic [W-1:0] rs;
    logic rc;
    total = int'(xa) + int'(xb) + int'(xc);
    run_add(xa, xb, xc, lat, bc, dc, rs, rc);
    checks++;
    if (rs !== W'(total % 256) || rc !== 1'(total / 256)) begin
      failures++;
      $display("[TB] FAIL %s result got %h/%b want %h/%b", name, rs, rc, W'(total % 256), 1'(total / 256));
    end
    checks++;
    if (lat != W + 1 || bc != W || dc != 1) begin
      failures++;
      $display("[TB] FAIL %s timing got lat=%0d busy=%0d done=%0d want %0d/%0d/1", name, lat, bc, dc, W + 1, W);
    end
  endtask

  task automatic test_directed();
    check_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0);
    check_add("add_ff_01", 8'hFF, 8'h01, 1'b0);
    check_add("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1);
    check_add("add_00_00", 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_ignore_start();
    int dc = 0, bc = 0;
    logic [W-1:0] rs = '0;
    logic rc = 1'b1;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin dc++; rs = sum; rc = cout; end
      start = (k == 3);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    start = 1'b0;
    checks++;
    if (rs !== 8'h46 || rc !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ignore_start result got %h/%b want 46/0", rs, rc);
    end
    checks++;
    if (dc != 1 || bc != W) begin
      failures++;
      $display("[TB] FAIL ignore_start pulses got done=%0d busy=%0d want 1/%0d", dc, bc, W);
    end
  endtask

  task automatic test_mid_reset();
    int dc = 0, lat, bc;
    logic [W-1:0] rs;
    logic rc;
    @(negedge clk);
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || sum !== 8'h46) begin
      failures++;
      $display("[TB] FAIL pre_reset got busy=%b sum=%h want 1/46", busy, sum);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout} !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset got busy=%b done=%b sum=%h cout=%b want all 0", busy, done, sum, cout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    checks++;
    if (dc != 0) begin
      failures++;
      $display("[TB] FAIL reset_discard got activity=%0d want 0", dc);
    end
    run_add(8'h01, 8'h02, 1'b0, lat, bc, dc, rs, rc);
    checks++;
    if (rs !== 8'h03 || rc !== 1'b0 || lat != W + 1) begin
      failures++;
      $display("[TB] FAIL after_reset got %h/%b lat=%0d want 03/0 lat=%0d", rs, rc, lat, W + 1);
    end
  endtask

  task automatic test_width1();
    logic [3:0] obs [4];
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      obs[k] = {busy1, done1, sum1, cout1};
    end
    checks++;
    if (obs[1] !== 4'b1000 || obs[2] !== 4'b0111 || obs[3][3:2] !== 2'b00) begin
      failures++;
      $display("[TB] FAIL width1 got %b %b %b want 1000 0111 00xx", obs[1], obs[2], obs[3]);
    end
  endtask

  task automatic test_back_to_back();
    int exp_val [3];
    int got_val [$];
    int got_idx [$];
    for (int j = 0; j < 3 * P; j++) begin
      @(negedge clk);
      if (done) begin
        got_val.push_back(int'({cout, sum}));
        got_idx.push_back(j);
      end
      start = 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (j % P == 0) exp_val[j / P] = int'(a) + int'(b) + int'(cin);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (P + 2) @(negedge clk);
    checks++;
    if (got_val.size() != 3) begin
      failures++;
      $display("[TB] FAIL b2b_count got %0d want 3", got_val.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_val[i] != exp_val[i] || got_idx[i] != i * P + W + 1) begin
          failures++;
          $display("[TB] FAIL b2b_%0d got %h at %0d want %h at %0d", i, got_val[i], got_idx[i], exp_val[i], i * P + W + 1);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      check_add("random", W'($urandom), W'($urandom), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_mid_reset();
    test_width1();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
